hexload_writer: RTL and testbench

- Runtime writer for the byte-wide ROM/RAM array; the runtime counterpart of the simulation-time `$readmemh` preload.
- Accepts a character stream in `$readmemh` hex-file format (hex words, whitespace, `@addr` directives) over a valid/ready handshake.
- Parses the stream and drives a simple synchronous write port into the memory array.
- Sits between a host/debug byte channel and the memory's write side.

---
 rtl/hexload_writer.sv | 152 +++++++++++++++
 tb/tb_hexload_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hexload_writer.sv
// hexload_writer: parses a hex-file-format character stream and drives a synchronous memory write port.
// Define HEXLOAD_COMMENT_EN to accept `//` line comments in the stream.
module hexload_writer #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);
  localparam int DD = (DATA_W + 3) / 4;
  localparam int AD = (ADDR_W + 3) / 4;
  localparam int ACC_W = (DATA_W > 4 * AD) ? DATA_W : 4 * AD;
  localparam int CNT_W = $clog2(((DD > AD) ? DD : AD) + 2);

  typedef enum logic [2:0] {
    IDLE, GAP, DATA, ADDR, DONE, ERR
`ifdef HEXLOAD_COMMENT_EN
    , SLASH, COMMENT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sh;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   addr_q, addr_d, word_cnt_q, word_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              fire, is_num, is_lo, is_up, is_hex, is_ws, is_at, term, wr_req, wr_ok, bad_end;
  logic [3:0]        nib;
  state_t            sep_st;

  always_comb begin
    is_num = in_char >= 8'h30 && in_char <= 8'h39;
    is_lo  = in_char >= 8'h61 && in_char <= 8'h66;
    is_up  = in_char >= 8'h41 && in_char <= 8'h46;
    is_hex = is_num | is_lo | is_up;
    is_ws  = in_char == 8'h20 || in_char == 8'h09 || in_char == 8'h0d || in_char == 8'h0a;
    is_at  = in_char == 8'h40;
    nib    = is_num ? in_char[3:0] : in_char[3:0] + 4'd9;
    acc_sh = (acc_q << 4) | ACC_W'(nib);
`ifdef HEXLOAD_COMMENT_EN
    term   = is_ws | (in_char == 8'h2f);
    sep_st = (in_char == 8'h2f) ? SLASH : GAP;
`else
    term   = is_ws;
    sep_st = GAP;
`endif
  end

  assign busy     = !(state_q inside {IDLE, DONE, ERR});
  assign in_ready = busy;
  assign fire     = in_valid & in_ready;
  assign done     = state_q == DONE;
  assign err      = state_q == ERR;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign word_cnt = word_cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_req  = 1'b0;
    bad_end = 1'b0;
    if (start) begin
      state_d = GAP;
      acc_d   = '0;
      cnt_d   = '0;
      addr_d  = '0;
    end else if (fire) begin
      case (state_q)
        GAP: begin
          state_d = is_hex ? DATA : is_at ? ADDR : term ? sep_st : ERR;
          acc_d   = is_hex ? ACC_W'(nib) : '0;
          cnt_d   = CNT_W'(is_hex);
        end
        DATA: begin
          acc_d   = is_hex ? acc_sh : acc_q;
          cnt_d   = cnt_q + CNT_W'(is_hex);
          wr_req  = term;
          state_d = is_hex ? ((cnt_q == CNT_W'(DD)) ? ERR : DATA) : term ? sep_st : ERR;
        end
        ADDR: begin
          acc_d   = is_hex ? acc_sh : acc_q;
          cnt_d   = cnt_q + CNT_W'(is_hex);
          addr_d  = (term && cnt_q != '0) ? {1'b0, acc_q[ADDR_W-1:0]} : addr_q;
          state_d = is_hex ? ((cnt_q == CNT_W'(AD) || (acc_sh >> ADDR_W) != '0) ? ERR : ADDR)
                           : (term && cnt_q != '0) ? sep_st : ERR;
        end
`ifdef HEXLOAD_COMMENT_EN
        SLASH:   state_d = (in_char == 8'h2f) ? COMMENT : ERR;
        COMMENT: state_d = (in_char == 8'h0a) ? GAP : COMMENT;
`endif
        default: ;
      endcase
`ifdef HEXLOAD_COMMENT_EN
      bad_end = state_d == ADDR || state_d == SLASH;
`else
      bad_end = state_d == ADDR;
`endif
      // in_last closes whatever token is still open after this character
      if (in_last && state_d != ERR) begin
        wr_req  = wr_req | (state_d == DATA);
        state_d = bad_end ? ERR : DONE;
      end
      if (wr_req && addr_q[ADDR_W]) state_d = ERR;
    end
    wr_ok      = wr_req & ~addr_q[ADDR_W];
    addr_d     = wr_ok ? addr_q + (ADDR_W+1)'(1) : addr_d;
    word_cnt_d = start ? '0 : word_cnt_q + (ADDR_W+1)'(wr_ok);
    wr_en_d    = wr_ok;
    wr_addr_d  = wr_ok ? addr_q[ADDR_W-1:0] : wr_addr_q;
    wr_data_d  = wr_ok ? acc_d[DATA_W-1:0] : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_hexload_writer.sv
// tb_hexload_writer: directed stimulus for hexload_writer with immediate-assertion checks.
module tb_hexload_writer;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready, wr_en, busy, done, err;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] word_cnt;
  int         checks = 0, errors = 0, nw = 0, base = 0;
  logic [1:0] log_a [0:63];
  logic [7:0] log_d [0:63];

  always #5 clk = ~clk;

  hexload_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always @(negedge clk)
    if (wr_en && nw < 64) begin
      log_a[nw] = wr_addr;
      log_d[nw] = wr_data;
      nw++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic last);
    int n = 0;
    in_char = c; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (in_ready) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && i == s.len() - 1);
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = nw;
  endtask

  task automatic settle;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [1:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, 32'(log_a[base + i]), 32'(a));
    chk({tag, "_data"}, 32'(log_d[base + i]), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wcnt", 32'(word_cnt), 0);
    chk("rst_wdata", 32'(wr_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 0);

    do_start;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(in_ready), 1);
    send_str("AB CD 01 7f", 1'b1);
    settle;
    chk("t1_nw", 32'(nw - base), 4);
    chk_wr("t1_w0", 0, 2'd0, 8'hAB);
    chk_wr("t1_w1", 1, 2'd1, 8'hCD);
    chk_wr("t1_w2", 2, 2'd2, 8'h01);
    chk_wr("t1_w3", 3, 2'd3, 8'h7F);
    chk("t1_wcnt", 32'(word_cnt), 4);
    chk("t1_done", 32'(done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy_end", 32'(busy), 0);

    do_start;
    chk("t2_done_clr", 32'(done), 0);
    send_str("@2 11 22 33", 1'b1);
    settle;
    chk("t2_nw", 32'(nw - base), 2);
    chk_wr("t2_w0", 0, 2'd2, 8'h11);
    chk_wr("t2_w1", 1, 2'd3, 8'h22);
    chk("t2_err", 32'(err), 1);
    chk("t2_done", 32'(done), 0);
    chk("t2_wcnt", 32'(word_cnt), 2);

    do_start;
    chk("t3_err_clr", 32'(err), 0);
    send_str("12 G", 1'b0);
    chk("t3_ready_drop", 32'(in_ready), 0);
    settle;
    chk("t3_nw", 32'(nw - base), 1);
    chk_wr("t3_w0", 0, 2'd0, 8'h12);
    chk("t3_err", 32'(err), 1);
    chk("t3_done", 32'(done), 0);

    do_start;
    send_str("123 ", 1'b0);
    settle;
    chk("t4_nw", 32'(nw - base), 0);
    chk("t4_err", 32'(err), 1);

    do_start;
    send(8'h35, 1'b0);
    @(negedge clk);
    send(8'h0a, 1'b0);
    chk("t5_wr0_en", 32'(wr_en), 1);
    chk("t5_wr0_addr", 32'(wr_addr), 0);
    chk("t5_wr0_data", 32'(wr_data), 32'h05);
    @(negedge clk);
    chk("t5_wr0_low", 32'(wr_en), 0);
    send(8'h39, 1'b1);
    chk("t5_wr1_en", 32'(wr_en), 1);
    chk("t5_wr1_addr", 32'(wr_addr), 1);
    chk("t5_wr1_data", 32'(wr_data), 32'h09);
    @(negedge clk);
    chk("t5_wr1_low", 32'(wr_en), 0);
    settle;
    chk("t5_nw", 32'(nw - base), 2);
    chk("t5_done", 32'(done), 1);
    chk("t5_wcnt", 32'(word_cnt), 2);

    do_start;
    send_str("11 2", 1'b0);
    do_start;
    chk("t6_wcnt_clr", 32'(word_cnt), 0);
    chk("t6_busy", 32'(busy), 1);
    send_str("3 ", 1'b0);
    settle;
    chk("t6_nw", 32'(nw - base), 1);
    chk_wr("t6_w0", 0, 2'd0, 8'h03);
    chk("t6_wcnt", 32'(word_cnt), 1);

    do_start;
    send_str("@4", 1'b0);
    settle;
    chk("t7_addr_ovf_err", 32'(err), 1);

    do_start;
    send_str("@ ", 1'b0);
    settle;
    chk("t7_addr_empty_err", 32'(err), 1);

    do_start;
    send_str("4", 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    settle;
    chk("t8_nw", 32'(nw - base), 0);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_err", 32'(err), 0);
    chk("t8_wcnt", 32'(word_cnt), 0);

    do_start;
    send_str("// x\nAA", 1'b1);
    settle;
`ifdef HEXLOAD_COMMENT_EN
    chk("t9_nw", 32'(nw - base), 1);
    chk_wr("t9_w0", 0, 2'd0, 8'hAA);
    chk("t9_done", 32'(done), 1);
`else
    chk("t9_nw", 32'(nw - base), 0);
    chk("t9_err", 32'(err), 1);
    chk("t9_done", 32'(done), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
